// File: rtl/exe_div.sv
// exe_div: iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// Produces {remainder, quotient} after DIV_W iterations and requests a stall
// while busy. Optional macro MINIMIPS32_DIV_ZERO_FAST_EN: a zero divisor skips
// the iterations and finishes in one cycle with the forced result.
module exe_div #(
  parameter int unsigned DIV_W = 32
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [DIV_W-1:0]   div_opa,
  input  logic [DIV_W-1:0]   div_opb,
  input  logic               exe_advance,
  input  logic               flush,
  output logic               div_ready,
  output logic [2*DIV_W-1:0] div_result,
  output logic               stallreq_div
);

  localparam int unsigned CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [DIV_W-1:0]   dvs_q, dvs_d;
  logic [DIV_W-1:0]   opa_q, opa_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               zero_q, zero_d;
  logic               ready_q, ready_d;
  logic [2*DIV_W-1:0] result_q, result_d;

  logic [DIV_W:0]     rem_sh;
  logic [DIV_W+1:0]   diff;
  logic               qbit;
  logic [DIV_W-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;
  logic [DIV_W-1:0]   abs_a, abs_b;

  // One restoring step plus the final sign fix-up of the step's outputs
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DIV_W-1]};
    diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
    qbit    = ~diff[DIV_W+1];
    rem_nx  = qbit ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
    quo_nx  = {dvd_q[DIV_W-2:0], qbit};
    quo_fix = qneg_q ? (DIV_W'(0) - quo_nx) : quo_nx;
    rem_fix = rneg_q ? (DIV_W'(0) - rem_nx) : rem_nx;
    abs_a   = (div_signed & div_opa[DIV_W-1]) ? (DIV_W'(0) - div_opa) : div_opa;
    abs_b   = (div_signed & div_opb[DIV_W-1]) ? (DIV_W'(0) - div_opb) : div_opb;
  end

  // Next-state and datapath update; flush overrides start/iterate
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    opa_d    = opa_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    ready_d  = ready_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            dvd_d   = abs_a;
            dvs_d   = abs_b;
            opa_d   = div_opa;
            rneg_d  = div_signed & div_opa[DIV_W-1];
            qneg_d  = div_signed & (div_opa[DIV_W-1] ^ div_opb[DIV_W-1]);
            zero_d  = (div_opb == '0);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_ON;
`ifdef MINIMIPS32_DIV_ZERO_FAST_EN
            if (div_opb == '0) begin
              state_d  = S_END;
              ready_d  = 1'b1;
              result_d = {div_opa, {DIV_W{1'b1}}};
            end
`endif
          end
        end
        S_ON: begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            state_d  = S_END;
            ready_d  = 1'b1;
            result_d = zero_q ? {opa_q, {DIV_W{1'b1}}} : {rem_fix, quo_fix};
          end
        end
        S_END: begin
          if (exe_advance) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      opa_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      opa_q    <= opa_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign div_ready    = ready_q;
  assign div_result   = result_q;
  assign stallreq_div = ~cpu_rst & ~flush &
                        (((state_q == S_IDLE) & div_start) | (state_q == S_ON));

endmodule

// File: tb/tb_exe_div.sv
// Testbench for exe_div: directed and random divides against an arithmetic model.
module tb_exe_div;

  logic        clk = 1'b0;
  logic        cpu_rst, div_start, div_signed, exe_advance, flush;
  logic [31:0] div_opa, div_opb;
  logic        div_ready, stallreq_div;
  logic [63:0] div_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_result = 64'h0;

  exe_div #(.DIV_W(32)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (cpu_rst),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_opa     (div_opa),
    .div_opb     (div_opb),
    .exe_advance (exe_advance),
    .flush       (flush),
    .div_ready   (div_ready),
    .div_result  (div_result),
    .stallreq_div(stallreq_div)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit integer arithmetic truncates toward zero, remainder follows dividend
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit scramble, input int hold);
    logic [63:0] exp, held;
    int exp_cyc, n, stall_n;
    exp     = ref_div(a, b, s);
    exp_cyc = 33;
`ifdef MINIMIPS32_DIV_ZERO_FAST_EN
    if (b == 32'h0) exp_cyc = 1;
`endif
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = s; div_opa = a; div_opb = b; exe_advance = 1'b0;
    #1;
    n = 0; stall_n = 0;
    while (!div_ready && n < 200) begin
      if (stallreq_div) stall_n++;
      @(posedge clk); #1;
      if (scramble) begin
        div_opa = $urandom; div_opb = $urandom; div_signed = ~s;
      end
      n++;
    end
    check({tag, " cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, " stall_cycles"}, 64'(stall_n), 64'(exp_cyc));
    check({tag, " result"}, div_result, exp);
    check({tag, " stall_in_end"}, 64'(stallreq_div), 64'h0);
    held = div_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_ready"}, 64'(div_ready), 64'h1);
      check({tag, " hold_result"}, div_result, held);
      check({tag, " hold_stall"}, 64'(stallreq_div), 64'h0);
    end
    exe_advance = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; exe_advance = 1'b0;
    #1;
    check({tag, " ready_after_adv"}, 64'(div_ready), 64'h0);
    check({tag, " stall_after_adv"}, 64'(stallreq_div), 64'h0);
    last_result = exp;
  endtask

  initial begin
    int ups;
    logic [31:0] ra, rb;
    cpu_rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; exe_advance = 1'b0;
    flush = 1'b0; div_opa = 32'h0; div_opb = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    cpu_rst = 1'b0;
    #1;
    check("reset ready", 64'(div_ready), 64'h0);
    check("reset result", div_result, 64'h0);
    check("reset stall", 64'(stallreq_div), 64'h0);

    // Directed cases
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 0);
    check("divu_100_7 const", last_result, 64'h0000_0002_0000_000E);
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
    check("div_m7_2 const", last_result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    check("div_ovf const", last_result, 64'h0000_0000_8000_0000);
    run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0, 0);
    check("divu_5_0 const", last_result, 64'h0000_0005_FFFF_FFFF);
    run_div("div_neg_0", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b0, 0);
    run_div("hold_end", 32'd12345, 32'd67, 1'b0, 1'b0, 5);

    // Random operands; odd runs disturb operand inputs after the start cycle
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = $urandom;
        default: rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      endcase
      run_div("random", ra, rb, 1'($urandom_range(0, 1)), 1'(k % 2), k % 3);
    end

    // Flush during ON cycle 10
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; div_opa = 32'd1000; div_opb = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush stall_same_cycle", 64'(stallreq_div), 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0;
    #1;
    check("flush ready", 64'(div_ready), 64'h0);
    check("flush stall_after", 64'(stallreq_div), 64'h0);
    check("flush result_kept", div_result, last_result);
    ups = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_ready) ups++;
    end
    check("flush ready_never", 64'(ups), 64'h0);

    // Flush coincident with start in IDLE
    @(posedge clk); #1;
    div_start = 1'b1; flush = 1'b1; div_opa = 32'd50; div_opb = 32'd5;
    #1;
    check("flush_start stall", 64'(stallreq_div), 64'h0);
    @(posedge clk); #1;
    div_start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start stall_after", 64'(stallreq_div), 64'h0);
    check("flush_start ready", 64'(div_ready), 64'h0);
    run_div("after_flush", 32'd50, 32'd5, 1'b0, 1'b0, 0);

    // Reset during ON cycle 20
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b1; div_opa = 32'hDEAD_BEEF; div_opb = 32'd9;
    repeat (20) @(posedge clk);
    #1;
    cpu_rst = 1'b1;
    #1;
    check("rst stall_same_cycle", 64'(stallreq_div), 64'h0);
    @(posedge clk); #1;
    check("rst ready", 64'(div_ready), 64'h0);
    check("rst result", div_result, 64'h0);
    check("rst stall", 64'(stallreq_div), 64'h0);
    cpu_rst = 1'b0; div_start = 1'b0;
    run_div("after_rst", 32'hDEAD_BEEF, 32'd9, 1'b1, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
